// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receive controller and its neighbours: the pin
// synchronizer and line configuration on one side, and the data sampler,
// deserializer and start/parity/stop checkers on the other.
interface uart_rx_ctrl_if #(
  parameter int PRESC_W = 6
);
  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               strt_glitch;
  logic               par_err;
  logic               stop_err;
  logic [PRESC_W-1:0] edge_count;
  logic [3:0]         bit_count;
  logic               dat_samp_en;
  logic               deser_en;
  logic               strt_chk_en;
  logic               par_chk_en;
  logic               stp_chk_en;
  logic               data_valid;
  logic               frame_err;
  logic               parity_err;

  // Controller side: consumes line/checker results, drives counters and enables.
  modport master (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stop_err,
    output edge_count, bit_count, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );

  // Surrounding receive path: feeds the controller, obeys its enables.
  modport slave (
    output rx_in, prescale, par_en, strt_glitch, par_err, stop_err,
    input  edge_count, bit_count, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: oversample edge counter, bit counter and the
// IDLE/START/DATA/PARITY/STOP FSM that gates the sampler, deserializer and
// checkers and raises the frame-accepted strobe.
module uart_rx_ctrl #(
  parameter int PRESC_W   = 6,
  parameter int DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_ctrl_if.master   bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS + 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q;
  logic               frame_err_q;
  logic               parity_err_q;

  logic [PRESC_W-1:0] edge_end;
  logic [PRESC_W-1:0] edge_mid;
  logic               at_end;
  logic               at_mid;
  logic               start_fire;
  logic               stop_fire;

  // Bit timing derived from the prescale captured at frame start:
  // edge_end closes a bit, edge_mid is one past the checker sample point.
  assign edge_end   = presc_q - PRESC_W'(1);
  assign edge_mid   = (presc_q >> 1) + PRESC_W'(3);
  assign at_end     = (state != IDLE) && (edge_cnt == edge_end);
  assign at_mid     = (edge_cnt == edge_mid);
  assign start_fire = (state == IDLE) && !bus.rx_in;
  assign stop_fire  = (state == STOP) && at_mid;

  // Next-state decode; STOP leaves mid-bit so a following start edge is seen early.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.rx_in) state_nxt = START;
      START:   if (at_end) state_nxt = bus.strt_glitch ? IDLE : DATA;
      DATA:    if (at_end && (bit_cnt == LAST_DATA)) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (at_end) state_nxt = STOP;
      STOP:    if (at_mid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Edge/bit counters: held at zero in IDLE and cleared on any return to IDLE;
  // bit_cnt saturates at the parity/stop index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if ((state == IDLE) || (state_nxt == IDLE)) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (at_end) begin
      edge_cnt <= '0;
      if (bit_cnt < LAST_BIT) bit_cnt <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

  // Frame configuration is latched at the start edge so mid-frame changes are ignored.
  always_ff @(posedge clk) begin
    if (start_fire) begin
      presc_q  <= bus.prescale;
      par_en_q <= bus.par_en;
    end
  end

  // Sticky error flags: cleared at frame start, loaded at their check points.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else if (start_fire) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if ((state == PARITY) && at_end) parity_err_q <= bus.par_err;
      if (stop_fire)                   frame_err_q  <= bus.stop_err;
    end
  end

  assign bus.edge_count  = edge_cnt;
  assign bus.bit_count   = bit_cnt;
  assign bus.dat_samp_en = (state != IDLE);
  assign bus.deser_en    = (state == DATA) && at_mid;
  assign bus.strt_chk_en = (state == START);
  assign bus.par_chk_en  = (state == PARITY);
  assign bus.stp_chk_en  = (state == STOP);
  assign bus.data_valid  = stop_fire && !bus.stop_err && !parity_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.parity_err  = parity_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives whole frames bit by bit and checks
// strobe counts, strobe positions and sticky flags against hand-worked values.
module tb_uart_rx_ctrl;
  localparam int PRESC_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.PRESC_W(PRESC_W)) bus ();

  uart_rx_ctrl #(.PRESC_W(PRESC_W), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int cyc_n, n_deser, dser_bad, n_dv, n_par, viol;
  int dv_edge, dv_first, strt_rise, stop_edge, exp_mid;
  logic prev_strt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_deser = 0; dser_bad = 0; n_dv = 0; n_par = 0;
    dv_edge = -1; dv_first = -1; strt_rise = -1; stop_edge = -1;
  endtask

  // One clock; observe 1 ns after the edge and tally strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (bus.deser_en) begin
      n_deser++;
      if (bus.edge_count != PRESC_W'(exp_mid)) dser_bad++;
    end
    if (bus.data_valid) begin
      n_dv++;
      dv_edge = int'(bus.edge_count);
      if (n_dv == 1) dv_first = cyc_n;
    end
    if (bus.strt_chk_en && !prev_strt) strt_rise = cyc_n;
    prev_strt = bus.strt_chk_en;
    if (bus.par_chk_en) n_par++;
    if (bus.stp_chk_en) stop_edge = int'(bus.edge_count);
    if (bus.data_valid && (bus.strt_chk_en || bus.par_chk_en)) viol++;
    if (bus.bit_count > 4'd9) viol++;
  endtask

  // Serial line driver, LSB first, p clocks per bit; line returns high afterwards.
  task automatic drive_bits(input int p, input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      bus.rx_in = bits[i];
      repeat (p) cyc();
    end
    bus.rx_in = 1'b1;
  endtask

  function automatic logic [17:0] outs();
    return {bus.edge_count, bus.bit_count, bus.dat_samp_en, bus.deser_en,
            bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid,
            bus.frame_err, bus.parity_err};
  endfunction

  initial begin
    cyc_n = 0; viol = 0; prev_strt = 1'b0; exp_mid = 7;
    clr();
    rst = 1'b1;
    bus.rx_in = 1'b1; bus.prescale = 6'd8; bus.par_en = 1'b0;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stop_err = 1'b0;
    #12;
    chk("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    repeat (3) cyc();
    chk("idle_hold", 32'(outs()), 32'd0);

    // Test 1: P=8, no parity, 0x55, clean line.
    clr(); exp_mid = 7;
    drive_bits(8, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
    repeat (2) cyc();
    chk("t1_deser_count", 32'(n_deser), 32'd8);
    chk("t1_deser_edge", 32'(dser_bad), 32'd0);
    chk("t1_dv_count", 32'(n_dv), 32'd1);
    chk("t1_dv_edge", 32'(dv_edge), 32'd7);
    chk("t1_frame_err", 32'(bus.frame_err), 32'd0);
    chk("t1_no_parity_state", 32'(n_par), 32'd0);
    chk("t1_back_idle", 32'(bus.dat_samp_en), 32'd0);

    // Test 2: P=16 with parity, par_err set; config changed mid-frame must be ignored.
    clr(); exp_mid = 11;
    bus.prescale = 6'd16; bus.par_en = 1'b1; bus.par_err = 1'b1;
    bus.rx_in = 1'b0;
    cyc();
    chk("t2_start_entered", 32'(bus.strt_chk_en), 32'd1);
    bus.prescale = 6'd8; bus.par_en = 1'b0;
    repeat (15) cyc();
    drive_bits(16, {5'b0, 1'b1, 1'b0, 8'h0F}, 10);
    bus.par_err = 1'b0;
    repeat (2) cyc();
    chk("t2_deser_count", 32'(n_deser), 32'd8);
    chk("t2_deser_edge", 32'(dser_bad), 32'd0);
    chk("t2_parity_cycles", 32'(n_par), 32'd16);
    chk("t2_parity_err", 32'(bus.parity_err), 32'd1);
    chk("t2_no_dv", 32'(n_dv), 32'd0);
    chk("t2_stop_exit_edge", 32'(stop_edge), 32'd11);
    chk("t2_back_idle", 32'(bus.dat_samp_en), 32'd0);

    // Test 3: P=8 start glitch aborts the frame.
    clr(); exp_mid = 7;
    bus.strt_glitch = 1'b1;
    bus.rx_in = 1'b0;
    cyc(); cyc();
    bus.rx_in = 1'b1;
    repeat (6) cyc();
    chk("t3_start_e7", 32'({bus.strt_chk_en, bus.edge_count}), 32'({1'b1, 6'd7}));
    cyc();
    chk("t3_abort_bitcnt", 32'(bus.bit_count), 32'd0);
    chk("t3_abort_idle", 32'(bus.dat_samp_en), 32'd0);
    repeat (5) cyc();
    bus.strt_glitch = 1'b0;
    chk("t3_no_deser", 32'(n_deser), 32'd0);
    chk("t3_no_dv", 32'(n_dv), 32'd0);
    chk("t3_parity_err_cleared", 32'(bus.parity_err), 32'd0);

    // Test 4: stop error, then cleared by the next start.
    clr();
    bus.stop_err = 1'b1;
    drive_bits(8, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    repeat (2) cyc();
    chk("t4_frame_err", 32'(bus.frame_err), 32'd1);
    chk("t4_no_dv", 32'(n_dv), 32'd0);
    clr();
    bus.stop_err = 1'b0;
    bus.rx_in = 1'b0;
    cyc();
    chk("t4_frame_err_cleared", 32'(bus.frame_err), 32'd0);
    repeat (7) cyc();
    drive_bits(8, {7'b0, 1'b1, 8'hC3}, 9);
    repeat (2) cyc();
    chk("t4_second_dv", 32'(n_dv), 32'd1);

    // Test 5: back-to-back frames, one stop bit each.
    clr();
    drive_bits(8, {6'b0, 1'b1, 8'hA3, 1'b0}, 10);
    drive_bits(8, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (3) cyc();
    chk("t5_dv_count", 32'(n_dv), 32'd2);
    chk("t5_deser_count", 32'(n_deser), 32'd16);
    chk("t5_restart_gap", 32'(strt_rise - dv_first), 32'd2);

    // Test 6: reset mid-frame at DATA bit 4, edge 3.
    clr();
    bus.rx_in = 1'b0;
    repeat (8) cyc();
    bus.rx_in = 1'b1;
    repeat (28) cyc();
    chk("t6_pos", 32'({bus.bit_count, bus.edge_count}), 32'({4'd4, 6'd3}));
    chk("t6_deser_before", 32'(n_deser), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_reset_outputs", 32'(outs()), 32'd0);
    #20;
    rst = 1'b0;
    clr();
    repeat (20) cyc();
    chk("t6_idle_after", 32'(bus.dat_samp_en), 32'd0);
    chk("t6_no_dv", 32'(n_dv), 32'd0);
    chk("t6_no_deser", 32'(n_deser), 32'd0);

    chk("invariants", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
